// File: rtl/keybuf_reader.sv
// Debounces the two-slot keycode buffer, maps HID keycodes to 13 note indices and
// emits note-off/note-on events with a two-voice allocator over a valid/ready handshake.
module keybuf_reader #(
    parameter int unsigned STABLE_CYC = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] keybuffer,
    input  logic        ev_ready,
    output logic        ev_valid,
    output logic        ev_on,
    output logic [3:0]  ev_note,
    output logic        ev_voice,
    output logic [1:0]  voice_active,
    output logic [12:0] note_mask
);
    localparam int unsigned NOTES = 13;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYC);

    typedef enum logic [1:0] {IDLE, REL, PRS} state_t;

    state_t           state, state_n;
    logic [15:0]      in_q;
    logic [CNT_W-1:0] stab_cnt;
    logic [NOTES-1:0] rel_pend, rel_pend_n;
    logic [NOTES-1:0] prs_pend, prs_pend_n;
    logic [NOTES-1:0] tgt, tgt_n;
    logic [NOTES-1:0] note_mask_n;
    logic [1:0]       voice_active_n;
    logic [3:0]       voice_note0, voice_note0_n;
    logic [3:0]       voice_note1, voice_note1_n;
    logic             ev_valid_n, ev_on_n, ev_voice_n;
    logic [3:0]       ev_note_n;
    logic [NOTES-1:0] in_mask_c;
    logic             stable_c;
    logic             xfer_c;

    function automatic logic [NOTES-1:0] key_bit(input logic [7:0] code);
        logic [NOTES-1:0] b;
        b = '0;
        case (code)
            8'h04: b[0]  = 1'b1;
            8'h1A: b[1]  = 1'b1;
            8'h16: b[2]  = 1'b1;
            8'h08: b[3]  = 1'b1;
            8'h07: b[4]  = 1'b1;
            8'h09: b[5]  = 1'b1;
            8'h17: b[6]  = 1'b1;
            8'h0A: b[7]  = 1'b1;
            8'h1C: b[8]  = 1'b1;
            8'h0B: b[9]  = 1'b1;
            8'h18: b[10] = 1'b1;
            8'h0D: b[11] = 1'b1;
            8'h0E: b[12] = 1'b1;
            default: b = '0;
        endcase
        return b;
    endfunction

    function automatic logic [3:0] lowest(input logic [NOTES-1:0] m);
        logic [3:0] idx;
        idx = '0;
        for (int i = int'(NOTES) - 1; i >= 0; i--) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [NOTES-1:0] bit_of(input logic [3:0] n);
        return NOTES'(1) << n;
    endfunction

    // Voice currently sounding note n (voice 1 unless voice 0 holds it).
    function automatic logic holder(input logic [1:0] act, input logic [3:0] v0,
                                    input logic [3:0] n);
        return (act[0] && (v0 == n)) ? 1'b0 : 1'b1;
    endfunction

    assign in_mask_c = key_bit(in_q[15:8]) | key_bit(in_q[7:0]);
    assign stable_c  = (stab_cnt == STABLE_MAX);
    assign xfer_c    = ev_valid & ev_ready;

    // Next-state and next-event computation; event outputs are registered from these.
    always_comb begin
        state_n        = state;
        rel_pend_n     = rel_pend;
        prs_pend_n     = prs_pend;
        tgt_n          = tgt;
        note_mask_n    = note_mask;
        voice_active_n = voice_active;
        voice_note0_n  = voice_note0;
        voice_note1_n  = voice_note1;
        ev_valid_n     = ev_valid;
        ev_on_n        = ev_on;
        ev_note_n      = ev_note;
        ev_voice_n     = ev_voice;

        case (state)
            IDLE: begin
                if (stable_c && (in_mask_c != note_mask)) begin
                    rel_pend_n = note_mask & ~in_mask_c;
                    prs_pend_n = in_mask_c & ~note_mask;
                    tgt_n      = in_mask_c;
                    state_n    = REL;
                    if (rel_pend_n != '0) begin
                        ev_valid_n = 1'b1;
                        ev_on_n    = 1'b0;
                        ev_note_n  = lowest(rel_pend_n);
                        ev_voice_n = holder(voice_active, voice_note0, ev_note_n);
                    end
                end
            end
            REL: begin
                if (rel_pend == '0) begin
                    state_n = PRS;
                    if (prs_pend != '0) begin
                        ev_valid_n = 1'b1;
                        ev_on_n    = 1'b1;
                        ev_note_n  = lowest(prs_pend);
                        ev_voice_n = voice_active[0];
                    end
                end else if (xfer_c) begin
                    rel_pend_n               = rel_pend & ~bit_of(ev_note);
                    note_mask_n              = note_mask & ~bit_of(ev_note);
                    voice_active_n[ev_voice] = 1'b0;
                    if (rel_pend_n != '0) begin
                        ev_on_n    = 1'b0;
                        ev_note_n  = lowest(rel_pend_n);
                        ev_voice_n = holder(voice_active_n, voice_note0, ev_note_n);
                    end else begin
                        ev_valid_n = 1'b0;
                    end
                end
            end
            PRS: begin
                if (prs_pend == '0) begin
                    note_mask_n = tgt;
                    state_n     = IDLE;
                end else if (xfer_c) begin
                    prs_pend_n               = prs_pend & ~bit_of(ev_note);
                    note_mask_n              = note_mask | bit_of(ev_note);
                    voice_active_n[ev_voice] = 1'b1;
                    if (ev_voice) voice_note1_n = ev_note;
                    else          voice_note0_n = ev_note;
                    if (prs_pend_n != '0) begin
                        ev_on_n    = 1'b1;
                        ev_note_n  = lowest(prs_pend_n);
                        ev_voice_n = voice_active_n[0];
                    end else begin
                        ev_valid_n = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            in_q         <= '0;
            stab_cnt     <= '0;
            rel_pend     <= '0;
            prs_pend     <= '0;
            tgt          <= '0;
            note_mask    <= '0;
            voice_active <= '0;
            voice_note0  <= '0;
            voice_note1  <= '0;
            ev_valid     <= 1'b0;
            ev_on        <= 1'b0;
            ev_note      <= '0;
            ev_voice     <= 1'b0;
        end else begin
            state        <= state_n;
            in_q         <= keybuffer;
            if (keybuffer != in_q)        stab_cnt <= '0;
            else if (stab_cnt != STABLE_MAX) stab_cnt <= stab_cnt + CNT_W'(1);
            rel_pend     <= rel_pend_n;
            prs_pend     <= prs_pend_n;
            tgt          <= tgt_n;
            note_mask    <= note_mask_n;
            voice_active <= voice_active_n;
            voice_note0  <= voice_note0_n;
            voice_note1  <= voice_note1_n;
            ev_valid     <= ev_valid_n;
            ev_on        <= ev_on_n;
            ev_note      <= ev_note_n;
            ev_voice     <= ev_voice_n;
        end
    end
endmodule

// File: doc/keybuf_reader.md
# keybuf_reader

Consumer of the two-slot keyboard buffer. Samples the 16-bit `{upper, lower}` keycode buffer, debounces it, and maps USB HID keycodes to 13 chromatic note indices. On every change in the set of held notes it emits a note-off or note-on event, with a voice number from a two-voice allocator, over a valid/ready handshake to the tone generators.

## Interface
- `STABLE_CYC`, default 1000: number of consecutive cycles the buffer must stay unchanged before it is accepted. Legal range 1..65535.
- `clk` input 1: system clock, 50 MHz.
- `reset` input 1: synchronous, active-low. Sampled on the rising edge of `clk`; `reset==0` resets the block.
- `keybuffer` input 16: `[15:8]` upper slot, `[7:0]` lower slot. A value of 0x00 means the slot is empty.
- `ev_ready` input 1: the downstream block accepts the event.
- `ev_valid` output 1: an event is presented.
- `ev_on` output 1: 1 = note-on, 0 = note-off.
- `ev_note` output 4: note index, 0..12.
- `ev_voice` output 1: voice the event applies to.
- `voice_active` output 2: per-voice busy flags.
- `note_mask` output 13: committed set of held notes.

## Operation
- **Keycode map** (anything else is ignored; slot value 0x00 = no key):
  - 0x04→0, 0x1A→1, 0x16→2, 0x08→3, 0x07→4, 0x09→5, 0x17→6
  - 0x0A→7, 0x1C→8, 0x0B→9, 0x18→10, 0x0D→11, 0x0E→12
- **Mask build.** `new_mask` = OR of the decoded bits from both slots. Identical keycodes in both slots give a single bit.
- **Input register.** `in_q <= keybuffer` every cycle.
- **Stability counter.** `stab_cnt` (16 bit):
  - Cleared to 0 when `keybuffer != in_q`.
  - Otherwise increments, saturating at `STABLE_CYC`.
- **FSM states:** IDLE, REL, PRS.
  - **IDLE:** if `stab_cnt==STABLE_CYC` and `mask(in_q) != note_mask`:
    - latch `rel_pend = note_mask & ~new`
    - latch `prs_pend = new & ~note_mask`
    - latch `tgt = new`
    - go to REL.
  - **REL:**
    - If `rel_pend==0`: go to PRS next cycle.
    - Else: present an off event for the lowest set bit n, with `ev_voice` = the voice holding n.
    - On handshake: clear that bit, free the voice, clear `note_mask[n]`.
  - **PRS:**
    - If `prs_pend==0`: set `note_mask = tgt` and go to IDLE next cycle.
    - Else: present an on event for the lowest set bit, with `ev_voice` = the lowest free voice.
    - On handshake: mark that voice busy holding n, set `note_mask[n]`, clear the pending bit.
- **Ordering.** Releases always precede presses. At most 2 held notes means a free voice always exists at PRS.
- **Input changes while not IDLE** are not lost. They are evaluated against the updated `note_mask` on return to IDLE, so transients that net to no change are coalesced.
- **Voice table:** `voice_note[1:0]` (4 bit each) and `voice_active[1:0]`.
- **Reset values:**
  - `ev_valid=0`, `ev_on=0`, `ev_note=0`, `ev_voice=0`
  - `voice_active=0`, `note_mask=0`
  - `in_q=0`, `stab_cnt=0`, state IDLE.

## Timing
- All outputs are registered.
- **Latency.** Let keybuffer change at the edge ending cycle k and then stay constant.
  - First `ev_valid` rises at edge k+STABLE_CYC+2+s, where s = number of skipped (empty) REL cycles.
  - s=0 when releases exist; s=1 for press-only changes.
- **Handshake:**
  - An event transfers on a rising edge with `ev_valid & ev_ready`.
  - While `ev_valid=1 & ev_ready=0`, `ev_on`, `ev_note` and `ev_voice` hold stable.
  - The next event may be presented the cycle after a transfer, so back-to-back events are possible with `ev_ready` held high.
  - `ev_valid` never deasserts without a transfer, except on reset.
- **Per-event updates.** `voice_active` and `note_mask` update on the transfer edge, except the final `note_mask=tgt` commit at the PRS-empty cycle.
- **Input glitches.** Changes lasting fewer than `STABLE_CYC` cycles produce no event.
- **Buffer clear.** The upstream periodic buffer clear (all-zero for ≥ `STABLE_CYC` cycles) produces off events like a real release.
- **Reset mid-handshake.** `ev_valid=0` at the first edge with `reset==0`. All pending events and voice state are discarded; the downstream block must treat reset as all-notes-off.

## Test plan
1. **Single press.** After reset, keybuffer=0x0004 held ≥1010 cycles (`STABLE_CYC`=1000), `ev_ready`=1 → exactly one event {on=1, note=0, voice=0}; `note_mask`=0x0001; `voice_active`=01.
2. **Second key.** From 1, keybuffer=0x0D04 → one event {on=1, note=11, voice=1}; `voice_active`=11; `note_mask`=0x0801.
3. **Release one of two.** From 2, keybuffer=0x000D → one event {on=0, note=0, voice=0}; no event for note 11; `voice_active`=10.
4. **Swap both keys, with backpressure.** From 2, keybuffer=0x0E1A with `ev_ready` low for 10 cycles at each event → events in order {off,0,v0}, {off,11,v1}, {on,1,v0}, {on,12,v1}; fields stable while stalled.
5. **Filtering:**
   - keybuffer pulse 0x0009 for 500 cycles, then 0x0000 → no events.
   - keybuffer=0x2C00 (unmapped) → no events.
   - keybuffer=0x0404 → single {on, 0, v0}.
6. **Reset mid-event.** Assert `reset`=0 for 1 cycle while `ev_valid`=1 and `ev_ready`=0 → `ev_valid`=0, `voice_active`=0, `note_mask`=0 at the next edge. A re-held 0x0004 then yields {on, 0, v0}.
